// File: rtl/goertzel_pkg.sv
// Shared types and constants for the Goertzel sample front end.
package goertzel_pkg;

  // Default frame geometry.
  localparam int NS_DEF = 100000;
  localparam int DW_DEF = 8;

  // Acquisition state of the sample front end.
  typedef enum logic [1:0] {
    IDLE,
    ARMED,
    RUN,
    DONE
  } fe_state_t;

  // Bit masks for the front-end fields of the SPI STATUS register.
  localparam logic [3:0] FE_BUSY     = 4'b0001;
  localparam logic [3:0] FE_DONE     = 4'b0010;
  localparam logic [3:0] FE_ERR_PN   = 4'b0100;
  localparam logic [3:0] FE_ERR_DROP = 4'b1000;

endpackage

// File: rtl/sample_frontend_if.sv
// Sample stream from the front end to every Goertzel unit.
// No ready signal: consumers always accept a strobe.
interface sample_frontend_if #(
  parameter int DW = 8,
  parameter int CW = 3
);

  logic          smp_valid_o;
  logic [DW-1:0] smp_data_o;
  logic          smp_first_o;
  logic          smp_last_o;
  logic [CW-1:0] smp_idx_o;

  // Front end drives the stream.
  modport master (
    output smp_valid_o,
    output smp_data_o,
    output smp_first_o,
    output smp_last_o,
    output smp_idx_o
  );

  // Goertzel units observe the stream.
  modport slave (
    input smp_valid_o,
    input smp_data_o,
    input smp_first_o,
    input smp_last_o,
    input smp_idx_o
  );

endinterface

// File: rtl/diff_rx.sv
// Registers a W-bit differential p/n bus. data_r carries the p legs;
// fault_r flags any bit whose two legs are equal (not complementary).
module diff_rx #(
  parameter int W = 1
) (
  input  logic         clk,
  input  logic         rstn,
  input  logic [W-1:0] p,
  input  logic [W-1:0] n,
  output logic [W-1:0] data_r,
  output logic         fault_r
);

  // Capture the pair and its complementarity check in one stage.
  always_ff @(posedge clk) begin
    // NOTE: state is written with <= so every flop samples pre-edge values,
    // independent of the order the simulator evaluates processes.
    if (!rstn) begin
      data_r  <= '0;
      fault_r <= 1'b0;
    end else begin
      data_r  <= p;
      fault_r <= |(p ~^ n);
    end
  end

endmodule

// File: rtl/sample_frontend.sv
// Differential sample receiver and frame sequencer for the Goertzel bank.
// Stage 1 (diff_rx) registers the raw pairs; stage 2 checks them, converts
// the sample to two's complement and emits exactly NS strobes per frame.
module sample_frontend
  import goertzel_pkg::*;
#(
  parameter int NS        = NS_DEF,
  parameter int DW        = DW_DEF,
  parameter int SIGNED_IN = 0,
  parameter int CW        = $clog2(NS)
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              arm_i,
  input  logic              enable_p,
  input  logic              enable_n,
  input  logic [DW-1:0]     sample_p,
  input  logic [DW-1:0]     sample_n,
  sample_frontend_if.master smp,
  output logic              busy_o,
  output logic              done_o,
  output logic              err_pn_o,
  output logic              err_drop_o,
  output logic [15:0]       pn_err_cnt_o
);

  // Stage 1: registered pairs.
  logic          en_r;
  logic          en_fault_r;
  logic [DW-1:0] smp_r;
  logic          smp_fault_r;

  diff_rx #(.W(1)) u_en_rx (
    .clk     (clk),
    .rstn    (rstn),
    .p       (enable_p),
    .n       (enable_n),
    .data_r  (en_r),
    .fault_r (en_fault_r)
  );

  diff_rx #(.W(DW)) u_smp_rx (
    .clk     (clk),
    .rstn    (rstn),
    .p       (sample_p),
    .n       (sample_n),
    .data_r  (smp_r),
    .fault_r (smp_fault_r)
  );

  // A faulted enable pair reads as low, so it ends a running frame.
  logic          en_ok;
  logic          pn_fault;
  logic [DW-1:0] smp_conv;

  assign en_ok    = en_r & ~en_fault_r;
  assign pn_fault = en_fault_r | smp_fault_r;
  // Offset binary becomes two's complement by flipping the MSB.
  assign smp_conv = (SIGNED_IN != 0) ? smp_r : {~smp_r[DW-1], smp_r[DW-2:0]};

  // Stage 2 state.
  fe_state_t     state_q;
  fe_state_t     state_d;
  logic          valid_q;
  logic [DW-1:0] data_q;
  logic          first_q;
  logic          last_q;
  logic [CW-1:0] idx_q;
  logic          err_pn_q;
  logic          err_drop_q;
  logic [15:0]   pn_err_cnt_q;

  // FSM control strobes.
  logic emit;
  logic is_first;
  logic is_last;
  logic clr_stats;
  logic set_drop;
  logic active;

  assign active = (state_q == ARMED) || (state_q == RUN);

  // State register.
  always_ff @(posedge clk) begin
    if (!rstn) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // Next-state and control decode; idx_q is the index of the last emitted sample.
  always_comb begin
    // NOTE: every output gets a default before the case so no path leaves a
    // signal unassigned, which would infer a latch.
    state_d   = state_q;
    emit      = 1'b0;
    is_first  = 1'b0;
    is_last   = 1'b0;
    clr_stats = 1'b0;
    set_drop  = 1'b0;
    case (state_q)
      IDLE, DONE: begin
        if (arm_i) begin
          state_d   = ARMED;
          clr_stats = 1'b1;
        end
      end
      ARMED: begin
        if (en_ok) begin
          state_d  = RUN;
          emit     = 1'b1;
          is_first = 1'b1;
        end
      end
      RUN: begin
        if (en_ok) begin
          emit = 1'b1;
          if (idx_q + CW'(1) == CW'(NS - 1)) begin
            is_last = 1'b1;
            state_d = DONE;
          end
        end else begin
          set_drop = 1'b1;
          state_d  = DONE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Output stream registers and sticky status.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      valid_q      <= 1'b0;
      data_q       <= '0;
      first_q      <= 1'b0;
      last_q       <= 1'b0;
      idx_q        <= '0;
      err_pn_q     <= 1'b0;
      err_drop_q   <= 1'b0;
      pn_err_cnt_q <= '0;
    end else begin
      valid_q <= emit;
      first_q <= is_first;
      last_q  <= is_last;
      if (emit) data_q <= smp_conv;

      if (clr_stats)     idx_q <= '0;
      else if (is_first) idx_q <= '0;
      else if (emit)     idx_q <= idx_q + CW'(1);

      if (clr_stats) begin
        err_pn_q     <= 1'b0;
        err_drop_q   <= 1'b0;
        pn_err_cnt_q <= '0;
      end else begin
        if (set_drop) err_drop_q <= 1'b1;
        if (active && pn_fault) begin
          err_pn_q <= 1'b1;
          if (pn_err_cnt_q != 16'hFFFF) pn_err_cnt_q <= pn_err_cnt_q + 16'd1;
        end
      end
    end
  end

  assign smp.smp_valid_o = valid_q;
  assign smp.smp_data_o  = data_q;
  assign smp.smp_first_o = first_q;
  assign smp.smp_last_o  = last_q;
  assign smp.smp_idx_o   = idx_q;

  assign busy_o       = active;
  assign done_o       = (state_q == DONE);
  assign err_pn_o     = err_pn_q;
  assign err_drop_o   = err_drop_q;
  assign pn_err_cnt_o = pn_err_cnt_q;

endmodule

// File: tb/tb_sample_frontend.sv
// Randomized bench for sample_frontend against a frame-level reference model.
module tb_sample_frontend;

  localparam int NS        = 8;
  localparam int DW        = 8;
  localparam int SIGNED_IN = 0;
  localparam int CW        = $clog2(NS);
  localparam int MAXT      = 4096;

  logic          clk      = 1'b0;
  logic          rstn     = 1'b0;
  logic          arm_i    = 1'b0;
  logic          enable_p = 1'b0;
  logic          enable_n = 1'b1;
  logic [DW-1:0] sample_p = '0;
  logic [DW-1:0] sample_n = '1;
  logic          busy_o;
  logic          done_o;
  logic          err_pn_o;
  logic          err_drop_o;
  logic [15:0]   pn_err_cnt_o;

  sample_frontend_if #(.DW(DW), .CW(CW)) smp_if ();

  sample_frontend #(
    .NS(NS), .DW(DW), .SIGNED_IN(SIGNED_IN), .CW(CW)
  ) dut (
    .clk          (clk),
    .rstn         (rstn),
    .arm_i        (arm_i),
    .enable_p     (enable_p),
    .enable_n     (enable_n),
    .sample_p     (sample_p),
    .sample_n     (sample_n),
    .smp          (smp_if),
    .busy_o       (busy_o),
    .done_o       (done_o),
    .err_pn_o     (err_pn_o),
    .err_drop_o   (err_drop_o),
    .pn_err_cnt_o (pn_err_cnt_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    int cyc;
    int data;
    bit first;
    bit last;
    int idx;
  } strobe_t;

  strobe_t       act_q[$];
  strobe_t       exp_q[$];
  bit            log_en_ok [MAXT];
  bit            log_fault [MAXT];
  logic [DW-1:0] log_data  [MAXT];

  int cyc     = 0;
  int n_tests = 0;
  int n_fail  = 0;
  int exp_idx;
  int exp_cnt;
  bit exp_drop;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_tests++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, want);
    end
  endtask

  // One clock: log the pins the DUT captures at this edge, then collect any strobe.
  task automatic tick();
    @(posedge clk);
    cyc++;
    if (cyc >= MAXT) begin
      $display("FAIL tick_budget: got %0d cycles, expected < %0d", cyc, MAXT);
      $fatal(1, "cycle budget exhausted");
    end
    log_en_ok[cyc] = enable_p & ~enable_n;
    log_fault[cyc] = (enable_p == enable_n) || ((sample_p ~^ sample_n) != '0);
    log_data[cyc]  = sample_p;
    @(negedge clk);
    if (smp_if.smp_valid_o)
      act_q.push_back('{cyc, int'(smp_if.smp_data_o), smp_if.smp_first_o,
                        smp_if.smp_last_o, int'(smp_if.smp_idx_o)});
  endtask

  // Drive one cycle of pins; fmask marks sample bits whose n leg copies the p leg.
  task automatic drive(input logic arm, input logic ep, input logic en,
                       input logic [DW-1:0] sp, input logic [DW-1:0] fmask);
    arm_i    = arm;
    enable_p = ep;
    enable_n = en;
    sample_p = sp;
    sample_n = ~sp ^ fmask;
    tick();
    arm_i = 1'b0;
  endtask

  task automatic idle();
    drive(1'b0, 1'b0, 1'b1, DW'($urandom), '0);
  endtask

  // Frame-level expectation for an arm captured at cycle a: the first good-enable
  // cycle from a onward is sample 0, consecutive good-enable cycles follow, the
  // frame ends after NS samples or at the first non-good enable. Each strobe
  // appears one cycle after its pins are captured. Faults count from a to the end.
  task automatic predict(input int a);
    int p;
    int k;
    int end_t;
    exp_q.delete();
    p = a;
    while (p < cyc && !log_en_ok[p]) p++;
    k = 0;
    while (k < NS && p + k <= cyc && log_en_ok[p + k]) begin
      exp_q.push_back('{p + k + 1, (int'(log_data[p + k]) - 128) & 255,
                        (k == 0), (k == NS - 1), k});
      k++;
    end
    exp_drop = (k < NS);
    end_t    = exp_drop ? p + k : p + NS - 1;
    exp_idx  = (k > 0) ? k - 1 : 0;
    exp_cnt  = 0;
    for (int t = a; t <= end_t && t <= cyc; t++)
      if (log_fault[t] && exp_cnt < 65535) exp_cnt++;
  endtask

  task automatic compare_frame(input string tag);
    check({tag, "_strobes"}, act_q.size(), exp_q.size());
    for (int i = 0; i < act_q.size() && i < exp_q.size(); i++) begin
      check($sformatf("%s_cyc%0d", tag, i),   act_q[i].cyc,   exp_q[i].cyc);
      check($sformatf("%s_data%0d", tag, i),  act_q[i].data,  exp_q[i].data);
      check($sformatf("%s_first%0d", tag, i), act_q[i].first, exp_q[i].first);
      check($sformatf("%s_last%0d", tag, i),  act_q[i].last,  exp_q[i].last);
      check($sformatf("%s_idx%0d", tag, i),   act_q[i].idx,   exp_q[i].idx);
    end
  endtask

  task automatic check_status(input string tag);
    check({tag, "_done"},     done_o,                1);
    check({tag, "_busy"},     busy_o,                0);
    check({tag, "_err_drop"}, err_drop_o,            exp_drop);
    check({tag, "_err_pn"},   err_pn_o,              (exp_cnt != 0));
    check({tag, "_pn_cnt"},   pn_err_cnt_o,          exp_cnt);
    check({tag, "_idx"},      smp_if.smp_idx_o,      exp_idx);
  endtask

  initial begin
    int       a;
    int       g;
    int       len;
    int       f;
    logic [7:0] fpos;
    logic     b;

    // Reset state
    repeat (3) idle();
    check("rst_valid",  smp_if.smp_valid_o, 0);
    check("rst_data",   smp_if.smp_data_o,  0);
    check("rst_idx",    smp_if.smp_idx_o,   0);
    check("rst_busy",   busy_o,             0);
    check("rst_done",   done_o,             0);
    check("rst_pn_cnt", pn_err_cnt_o,       0);
    check("rst_errs",   {err_pn_o, err_drop_o}, 0);
    rstn = 1'b1;
    repeat (2) idle();

    // 1: nominal frame 0x80..0x87 -> 0x00..0x07
    act_q.delete();
    a = cyc + 1;
    drive(1'b1, 1'b0, 1'b1, 8'h5A, '0);
    check("t1_busy_armed", busy_o, 1);
    for (int k = 0; k < NS; k++) drive(1'b0, 1'b1, 1'b0, 8'h80 + 8'(k), '0);
    repeat (4) idle();
    predict(a);
    compare_frame("t1");
    check_status("t1");
    check("t1_count", act_q.size(), 8);
    if (act_q.size() == 8) begin
      check("t1_first_data", act_q[0].data, 8'h00);
      check("t1_last_data",  act_q[7].data, 8'h07);
      check("t1_latency",    act_q[0].cyc,  a + 2);
    end

    // 2: early drop after 5 samples
    act_q.delete();
    a = cyc + 1;
    drive(1'b1, 1'b0, 1'b1, 8'h00, '0);
    for (int k = 0; k < 5; k++) drive(1'b0, 1'b1, 1'b0, DW'($urandom), '0);
    repeat (4) idle();
    predict(a);
    compare_frame("t2");
    check_status("t2");
    check("t2_drop",    err_drop_o,       1);
    check("t2_idx_hold", smp_if.smp_idx_o, 4);

    // 3: sample_n[3] == sample_p[3] on 3 cycles of the frame
    fpos = '0;
    for (int i = 0; i < 200 && $countones(fpos) < 3; i++) fpos[$urandom_range(0, 7)] = 1'b1;
    act_q.delete();
    a = cyc + 1;
    drive(1'b1, 1'b0, 1'b1, 8'h00, '0);
    for (int k = 0; k < NS; k++)
      drive(1'b0, 1'b1, 1'b0, DW'($urandom), fpos[k] ? 8'h08 : 8'h00);
    repeat (4) idle();
    predict(a);
    compare_frame("t3");
    check_status("t3");
    check("t3_pn_cnt3", pn_err_cnt_o, 3);
    check("t3_count",   act_q.size(), 8);

    // 4: re-arm from DONE with enable already high
    act_q.delete();
    repeat (2) drive(1'b0, 1'b1, 1'b0, DW'($urandom), '0);
    a = cyc + 1;
    drive(1'b1, 1'b1, 1'b0, DW'($urandom), '0);
    check("t4_cnt_cleared",  pn_err_cnt_o,     0);
    check("t4_errpn_clear",  err_pn_o,         0);
    check("t4_idx_cleared",  smp_if.smp_idx_o, 0);
    for (int k = 1; k <= NS; k++) drive(1'b0, 1'b1, 1'b0, DW'($urandom), '0);
    repeat (4) idle();
    predict(a);
    compare_frame("t4");
    check_status("t4");
    if (act_q.size() > 0) check("t4_start_next", act_q[0].cyc, a + 1);

    // 6: arm during RUN is ignored
    act_q.delete();
    a = cyc + 1;
    drive(1'b1, 1'b0, 1'b1, 8'h00, '0);
    for (int k = 0; k < NS; k++) drive(k == 3, 1'b1, 1'b0, DW'($urandom), '0);
    repeat (4) idle();
    predict(a);
    compare_frame("t6");
    check_status("t6");
    check("t6_count", act_q.size(), 8);

    // 5: synchronous reset at idx3
    act_q.delete();
    a = cyc + 1;
    drive(1'b1, 1'b0, 1'b1, 8'h00, '0);
    for (int k = 0; k < 5; k++)
      drive(1'b0, 1'b1, 1'b0, DW'($urandom), (k == 1) ? 8'h08 : 8'h00);
    check("t5_idx_pre", smp_if.smp_idx_o, 3);
    check("t5_cnt_pre", pn_err_cnt_o,     1);
    rstn = 1'b0;
    drive(1'b0, 1'b1, 1'b0, DW'($urandom), '0);
    check("t5_valid", smp_if.smp_valid_o, 0);
    check("t5_data",  smp_if.smp_data_o,  0);
    check("t5_flags", {smp_if.smp_first_o, smp_if.smp_last_o}, 0);
    check("t5_idx",   smp_if.smp_idx_o,   0);
    check("t5_busy",  busy_o,             0);
    check("t5_done",  done_o,             0);
    check("t5_errs",  {err_pn_o, err_drop_o}, 0);
    check("t5_cnt",   pn_err_cnt_o,       0);
    rstn = 1'b1;
    act_q.delete();
    repeat (10) drive(1'b0, 1'b1, 1'b0, DW'($urandom), '0);
    check("t5_no_strobe", act_q.size(), 0);
    check("t5_idle_busy", busy_o,       0);
    check("t5_idle_done", done_o,       0);
    repeat (2) idle();

    // Randomized frames: gaps, lengths, enable and sample faults, stray arms
    for (int fr = 0; fr < 10; fr++) begin
      act_q.delete();
      a = cyc + 1;
      drive(1'b1, 1'b0, 1'b1, DW'($urandom), '0);
      g = $urandom_range(0, 2);
      for (int i = 0; i < g; i++) begin
        b = 1'($urandom);
        if ($urandom_range(0, 2) == 0) drive(1'b0, b, b, DW'($urandom), '0);
        else                           drive(1'b0, 1'b0, 1'b1, DW'($urandom), '0);
      end
      len = $urandom_range(2, NS + 2);
      f   = ($urandom_range(0, 3) == 0) ? $urandom_range(1, len - 1) : len;
      for (int k = 0; k < len; k++) begin
        logic [DW-1:0] m;
        m = ($urandom_range(0, 3) == 0) ? DW'($urandom_range(1, 255)) : '0;
        if (k == f) begin
          b = 1'($urandom);
          drive(1'b0, b, b, DW'($urandom), m);
        end else begin
          drive((k >= 1) && (k < ((f < NS) ? f : NS)) && ($urandom_range(0, 4) == 0),
                1'b1, 1'b0, DW'($urandom), m);
        end
      end
      repeat (4) idle();
      predict(a);
      compare_frame($sformatf("rnd%0d", fr));
      check_status($sformatf("rnd%0d", fr));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
